core_mem_rd_arbiter: RTL and testbench

- Two-master to one-slave AXI4-Lite read-channel arbiter.
- Lets the instruction fetch unit (port 0) and the load path of the data memory controller (port 1) share one memory read port, for unified-memory builds.
- Sits between the core's read masters and the memory/interconnect read slave.
- Allows one outstanding transaction; the grant is held from AR acceptance until the R handshake completes.

---
 rtl/core_mem_rd_arbiter_pkg.sv | 17 +
 rtl/core_mem_rd_arbiter_rr_arb2.sv | 34 +++
 rtl/core_mem_rd_arbiter.sv | 109 ++++++++++
 tb/tb_core_mem_rd_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_rd_arbiter_pkg.sv
// Shared encodings for the two-master AXI4-Lite read arbiter.
package core_mem_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int ARB_P_IFETCH = 0;
    localparam int ARB_P_LOAD   = 1;

endpackage

// File: rtl/core_mem_rd_arbiter_rr_arb2.sv
// 2-way grant unit (module core_rr_arb2). Round-robin by default;
// CORE_RDARB_FIXED_PRIO_EN makes the load port win every tie.
module core_rr_arb2
    import core_mem_rd_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

`ifdef CORE_RDARB_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = i_last;
`endif

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01: o_gnt[ARB_P_IFETCH] = 1'b1;
            2'b10: o_gnt[ARB_P_LOAD]   = 1'b1;
            2'b11: begin
`ifdef CORE_RDARB_FIXED_PRIO_EN
                o_gnt[ARB_P_LOAD] = 1'b1;
`else
                // Tie goes to whichever port did not win last time.
                if (i_last) o_gnt[ARB_P_IFETCH] = 1'b1;
                else        o_gnt[ARB_P_LOAD]   = 1'b1;
`endif
            end
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/core_mem_rd_arbiter.sv
// Two-master to one-slave AXI4-Lite read arbiter, one outstanding transaction.
// Tie policy selectable with CORE_RDARB_FIXED_PRIO_EN (see core_rr_arb2).
module core_mem_rd_arbiter
    import core_mem_rd_arbiter_pkg::*;
#(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  NRST,
    input  logic [AXI_AWIDTH-1:0] S0_ARADDR,
    input  logic                  S0_ARVALID,
    output logic                  S0_ARREADY,
    output logic [AXI_DWIDTH-1:0] S0_RDATA,
    output logic [1:0]            S0_RRESP,
    output logic                  S0_RVALID,
    input  logic                  S0_RREADY,
    input  logic [AXI_AWIDTH-1:0] S1_ARADDR,
    input  logic                  S1_ARVALID,
    output logic                  S1_ARREADY,
    output logic [AXI_DWIDTH-1:0] S1_RDATA,
    output logic [1:0]            S1_RRESP,
    output logic                  S1_RVALID,
    input  logic                  S1_RREADY,
    output logic [AXI_AWIDTH-1:0] M_ARADDR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [AXI_DWIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);

    arb_state_t            r_state;
    logic                  r_owner;
    logic                  r_last;
    logic                  r_arvalid;
    logic [AXI_AWIDTH-1:0] r_araddr;

    logic [1:0] w_gnt;
    logic       w_idle;
    logic       w_data;
    logic       w_own0;
    logic       w_own1;

    core_rr_arb2 u_arb (
        .i_req  ({S1_ARVALID, S0_ARVALID}),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    // AR readies depend only on state and AR inputs; gated by NRST so every
    // output reads 0 while reset is held.
    assign w_idle     = (r_state == ARB_IDLE) & NRST;
    assign S0_ARREADY = w_idle & w_gnt[ARB_P_IFETCH];
    assign S1_ARREADY = w_idle & w_gnt[ARB_P_LOAD];

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state   <= ARB_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (|w_gnt) begin
                        r_araddr  <= w_gnt[ARB_P_LOAD] ? S1_ARADDR : S0_ARADDR;
                        r_owner   <= w_gnt[ARB_P_LOAD];
                        r_last    <= w_gnt[ARB_P_LOAD];
                        r_arvalid <= 1'b1;
                        r_state   <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (M_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (M_RVALID && M_RREADY) r_state <= ARB_IDLE;
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_state   <= ARB_IDLE;
                end
            endcase
        end
    end

    assign M_ARVALID = r_arvalid;
    assign M_ARADDR  = r_araddr;

    // R channel is a pure combinational steer toward the owner during DATA.
    assign w_data   = (r_state == ARB_DATA);
    assign w_own0   = w_data & ~r_owner;
    assign w_own1   = w_data &  r_owner;
    assign M_RREADY = (w_own0 & S0_RREADY) | (w_own1 & S1_RREADY);

    assign S0_RVALID = w_own0 & M_RVALID;
    assign S0_RDATA  = w_own0 ? M_RDATA : '0;
    assign S0_RRESP  = w_own0 ? M_RRESP : 2'b00;
    assign S1_RVALID = w_own1 & M_RVALID;
    assign S1_RDATA  = w_own1 ? M_RDATA : '0;
    assign S1_RRESP  = w_own1 ? M_RRESP : 2'b00;

endmodule

// File: tb/tb_core_mem_rd_arbiter.sv
// Directed scoreboard bench for core_mem_rd_arbiter.
module tb_core_mem_rd_arbiter;
    import core_mem_rd_arbiter_pkg::*;

    logic        CLK, NRST;
    logic [31:0] S0_ARADDR, S1_ARADDR, M_ARADDR;
    logic        S0_ARVALID, S0_ARREADY, S1_ARVALID, S1_ARREADY;
    logic [31:0] S0_RDATA, S1_RDATA, M_RDATA;
    logic [1:0]  S0_RRESP, S1_RRESP, M_RRESP;
    logic        S0_RVALID, S0_RREADY, S1_RVALID, S1_RREADY;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    core_mem_rd_arbiter #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
        .CLK(CLK), .NRST(NRST),
        .S0_ARADDR(S0_ARADDR), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
        .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
        .S1_ARADDR(S1_ARADDR), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
        .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   tb_last = 1;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int tie_winner();
`ifdef CORE_RDARB_FIXED_PRIO_EN
        return 1;
`else
        return (tb_last == 1) ? 0 : 1;
`endif
    endfunction

    task automatic set_rready(input int p, input logic v);
        if (p == 0) S0_RREADY = v;
        else        S1_RREADY = v;
    endtask

    // R-channel monitor: every handshake pops one scoreboard entry.
    always @(negedge CLK) begin
        if (NRST) begin
            for (int p = 0; p < 2; p++) begin
                logic v, r;
                v = (p == 0) ? S0_RVALID : S1_RVALID;
                r = (p == 0) ? S0_RREADY : S1_RREADY;
                if (v && r) begin
                    hs_cnt++;
                    if (sb.size() == 0) begin
                        chk("r_unexpected", 64'(p), 64'hFFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("r_port", 64'(p), 64'(e.port));
                        chk("r_data", (p == 0) ? S0_RDATA : S1_RDATA, e.data);
                        chk("r_resp", (p == 0) ? S0_RRESP : S1_RRESP, e.resp);
                        chk("other_rvalid", (p == 0) ? S1_RVALID : S0_RVALID, 0);
                        chk("other_rdata", (p == 0) ? S1_RDATA : S0_RDATA, 0);
                        chk("other_rresp", (p == 0) ? S1_RRESP : S0_RRESP, 0);
                    end
                end
            end
        end
    end

    // Called with the request(s) already driven and the arbiter in IDLE.
    task automatic txn(input int p, input logic [31:0] addr, input int ar_wait,
                       input int r_wait, input int rrdy_wait,
                       input logic [31:0] data, input logic [1:0] resp, input bit drop);
        @(negedge CLK);
        chk("s0_arready_grant", S0_ARREADY, 64'(p == 0));
        chk("s1_arready_grant", S1_ARREADY, 64'(p == 1));
        chk("m_arvalid_pre", M_ARVALID, 0);
        tick();
        tb_last = p;
        if (drop) begin
            if (p == 0) S0_ARVALID = 1'b0;
            else        S1_ARVALID = 1'b0;
        end
        sb.push_back('{p, data, resp});
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge CLK);
            chk("m_arvalid_hold", M_ARVALID, 1);
            chk("m_araddr_hold", M_ARADDR, addr);
            chk("arready_busy", {S1_ARREADY, S0_ARREADY}, 0);
            tick();
        end
        M_ARREADY = 1'b1;
        @(negedge CLK);
        chk("m_arvalid", M_ARVALID, 1);
        chk("m_araddr", M_ARADDR, addr);
        chk("arready_addr", {S1_ARREADY, S0_ARREADY}, 0);
        tick();
        M_ARREADY = 1'b0;
        for (int i = 0; i < r_wait; i++) begin
            @(negedge CLK);
            chk("m_arvalid_data", M_ARVALID, 0);
            chk("rvalid_idle", {S1_RVALID, S0_RVALID}, 0);
            tick();
        end
        M_RDATA  = data;
        M_RRESP  = resp;
        M_RVALID = 1'b1;
        if (rrdy_wait > 0) set_rready(p, 1'b0);
        for (int i = 0; i < rrdy_wait; i++) begin
            @(negedge CLK);
            chk("m_rready_low", M_RREADY, 0);
            chk("owner_rvalid", (p == 0) ? S0_RVALID : S1_RVALID, 1);
            chk("m_araddr_data", M_ARADDR, addr);
            tick();
        end
        set_rready(p, 1'b1);
        @(negedge CLK);
        chk("m_rready", M_RREADY, 1);
        tick();
        M_RVALID = 1'b0;
        M_RDATA  = '0;
        M_RRESP  = 2'b00;
    endtask

    initial begin
        int hs0;
        NRST = 1'b0;
        S0_ARADDR = '0; S0_ARVALID = 1'b0; S0_RREADY = 1'b1;
        S1_ARADDR = '0; S1_ARVALID = 1'b0; S1_RREADY = 1'b1;
        M_ARREADY = 1'b0; M_RDATA = '0; M_RRESP = 2'b00; M_RVALID = 1'b0;
        repeat (3) tick();

        // Reset state, including with a request pending.
        S0_ARVALID = 1'b1;
        #1;
        chk("rst_s0_arready", S0_ARREADY, 0);
        chk("rst_m_arvalid", M_ARVALID, 0);
        chk("rst_m_araddr", M_ARADDR, 0);
        chk("rst_m_rready", M_RREADY, 0);
        chk("rst_rvalid", {S1_RVALID, S0_RVALID}, 0);
        S0_ARVALID = 1'b0;
        NRST = 1'b1;
        tick();

        // Single fetch.
        S0_ARADDR = 32'h10; S0_ARVALID = 1'b1;
        txn(0, 32'h10, 0, 2, 0, 32'h13, RESP_OKAY, 1'b1);

        // Both ports requesting continuously.
        S0_ARADDR = 32'h100; S1_ARADDR = 32'h2000;
        S0_ARVALID = 1'b1; S1_ARVALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = tie_winner();
            txn(w, (w == 1) ? 32'h2000 : 32'h100, 0, 1, 0, 32'hA0 + 32'(k), RESP_OKAY, 1'b0);
        end
        S0_ARVALID = 1'b0; S1_ARVALID = 1'b0;
        tick();

        // Backpressure on AR and R.
        hs0 = hs_cnt;
        S1_ARADDR = 32'h300; S1_ARVALID = 1'b1;
        txn(1, 32'h300, 5, 1, 3, 32'h303, RESP_OKAY, 1'b1);
        chk("bp_one_handshake", 64'(hs_cnt - hs0), 1);

        // Error response passthrough.
        S0_ARADDR = 32'h20; S0_ARVALID = 1'b1;
        txn(0, 32'h20, 0, 0, 0, 32'hDEADBEEF, RESP_SLVERR, 1'b1);

        // Spurious M_RVALID in IDLE.
        M_RVALID = 1'b1; M_RDATA = 32'hBAD; M_RRESP = RESP_DECERR;
        @(negedge CLK);
        chk("spur_m_rready", M_RREADY, 0);
        chk("spur_rvalid", {S1_RVALID, S0_RVALID}, 0);
        chk("spur_m_arvalid", M_ARVALID, 0);
        tick();
        M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
        S1_ARADDR = 32'h8; S1_ARVALID = 1'b1;
        txn(1, 32'h8, 0, 0, 0, 32'hB, RESP_OKAY, 1'b1);

        // Reset in the middle of DATA.
        S0_ARADDR = 32'h40; S0_ARVALID = 1'b1;
        tick();
        S0_ARVALID = 1'b0;
        M_ARREADY = 1'b1;
        tick();
        M_ARREADY = 1'b0;
        S0_RREADY = 1'b0;
        M_RVALID = 1'b1; M_RDATA = 32'h55; M_RRESP = RESP_SLVERR;
        #2;
        chk("mid_s0_rvalid", S0_RVALID, 1);
        NRST = 1'b0;
        #1;
        chk("arst_m_arvalid", M_ARVALID, 0);
        chk("arst_m_araddr", M_ARADDR, 0);
        chk("arst_m_rready", M_RREADY, 0);
        chk("arst_s0_r", {S0_RVALID, S0_RRESP, S0_RDATA}, 0);
        chk("arst_s1_r", {S1_RVALID, S1_RRESP, S1_RDATA}, 0);
        chk("arst_arready", {S1_ARREADY, S0_ARREADY}, 0);
        M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
        S0_RREADY = 1'b1;
        tick();
        NRST = 1'b1;
        tb_last = 1;
        tick();
        S1_ARADDR = 32'h4; S1_ARVALID = 1'b1;
        txn(1, 32'h4, 0, 1, 0, 32'h7, RESP_OKAY, 1'b1);

        repeat (2) tick();
        chk("sb_drained", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
